// File: rtl/fixed_point_multiplier_node_pkg.sv
// kpn_fixed_pkg: shared definitions for the KPN fixed-point node library.
// Holds the node FSM state encoding, default Q-format constants and helpers
// returning the representable max/min of a signed WIDTH-bit token.
package kpn_fixed_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_FRAC  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_MUL,
    ST_RND,
    ST_HOLD,
    ST_WRITE
  } state_t;

  function automatic longint q_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint q_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixed_point_multiplier_node_if.sv
// Blocking-FIFO handshake bundle of the multiplier node.
//   entry_1/entry_2 : operand tokens from input FIFOs (valid the cycle after rd)
//   empty_1/empty_2 : input FIFO empty flags
//   full            : output FIFO full flag
//   rd              : pop strobe to both input FIFOs
//   wr              : push strobe to the output FIFO
//   output_1, ovf   : result token and its overflow flag
// master = node side, slave = FIFO side.
interface fixed_point_multiplier_node_if
  import kpn_fixed_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] entry_1;
  logic [WIDTH-1:0] entry_2;
  logic             empty_1;
  logic             empty_2;
  logic             full;
  logic             rd;
  logic             wr;
  logic [WIDTH-1:0] output_1;
  logic             ovf;

  modport master (
    input  entry_1, entry_2, empty_1, empty_2, full,
    output rd, wr, output_1, ovf
  );

  modport slave (
    output entry_1, entry_2, empty_1, empty_2, full,
    input  rd, wr, output_1, ovf
  );

endinterface

// File: rtl/fixed_point_multiplier_node_round_sat.sv
// fixed_point_round_sat: combinational renormalisation of a 2*WIDTH signed
// product back to Q(WIDTH-FRAC).FRAC.
//   i_product : full-width signed product
//   o_result  : WIDTH-bit result (rounded half up or truncated, then
//               saturated or wrapped)
//   o_ovf     : shifted value fell outside the WIDTH-bit signed range
module fixed_point_round_sat
  import kpn_fixed_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter bit          ROUND = 1'b1,
  parameter bit          SAT   = 1'b1
) (
  input  logic signed [2*WIDTH-1:0] i_product,
  output logic        [WIDTH-1:0]   o_result,
  output logic                      o_ovf
);

  localparam int unsigned EW = 2 * WIDTH + 1;

  localparam logic signed [EW-1:0] W_MAX = EW'(q_max(WIDTH));
  localparam logic signed [EW-1:0] W_MIN = EW'(q_min(WIDTH));
  localparam logic signed [EW-1:0] HALF  = ROUND ? (EW'(1) << (FRAC - 1)) : '0;

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_shift;
  logic                 w_hi;
  logic                 w_lo;

  // One extra bit keeps the rounding add from overflowing for any product.
  always_comb begin
    w_ext    = {i_product[2*WIDTH-1], i_product} + HALF;
    w_shift  = w_ext >>> FRAC;
    w_hi     = (w_shift > W_MAX);
    w_lo     = (w_shift < W_MIN);
    o_ovf    = w_hi | w_lo;
    o_result = w_shift[WIDTH-1:0];
    if (SAT && w_hi) begin
      o_result = W_MAX[WIDTH-1:0];
    end else if (SAT && w_lo) begin
      o_result = W_MIN[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_multiplier_node.sv
// fixed_point_multiplier_node: KPN process node multiplying one token from
// each of two input FIFOs and writing the renormalised product to an output
// FIFO. One token in flight; rd-to-wr latency 4 cycles without back-pressure.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : FIFO handshake (master modport)
module fixed_point_multiplier_node
  import kpn_fixed_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter bit          ROUND = 1'b1,
  parameter bit          SAT   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  fixed_point_multiplier_node_if.master bus
);

  state_t                    r_state;
  logic signed [WIDTH-1:0]   r_a;
  logic signed [WIDTH-1:0]   r_b;
  logic signed [2*WIDTH-1:0] r_prod;
  logic        [WIDTH-1:0]   r_out;
  logic                      r_ovf;
  logic                      r_rd;
  logic                      r_wr;

  logic        [WIDTH-1:0]   w_res;
  logic                      w_ovf;

  fixed_point_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_round_sat (
    .i_product (r_prod),
    .o_result  (w_res),
    .o_ovf     (w_ovf)
  );

  // Strobes are registered: they are set on the transition into READ/WRITE
  // so they are high exactly while the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.empty_1 && !bus.empty_2) begin
            r_state <= ST_READ;
            r_rd    <= 1'b1;
          end
        end
        ST_READ: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_a     <= bus.entry_1;
          r_b     <= bus.entry_2;
          r_state <= ST_MUL;
        end
        ST_MUL: begin
          r_prod  <= r_a * r_b;
          r_state <= ST_RND;
        end
        ST_RND: begin
          r_out <= w_res;
          r_ovf <= w_ovf;
          if (!bus.full) begin
            r_state <= ST_WRITE;
            r_wr    <= 1'b1;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!bus.full) begin
            r_state <= ST_WRITE;
            r_wr    <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rd       = r_rd;
  assign bus.wr       = r_wr;
  assign bus.output_1 = r_out;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_fixed_point_multiplier_node.sv
// Scoreboard bench for fixed_point_multiplier_node: three instances
// (round+sat, round+wrap, truncate+sat), each with a queue-backed input FIFO
// model and a monitor that checks every output write against expectations.
module tb_fixed_point_multiplier_node;
  import kpn_fixed_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit P_ROUND = (g != 2);
    localparam bit P_SAT   = (g != 1);

    fixed_point_multiplier_node_if #(.WIDTH(16)) bus ();

    fixed_point_multiplier_node #(
      .WIDTH (16),
      .FRAC  (8),
      .ROUND (P_ROUND),
      .SAT   (P_SAT)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
    );

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    exp_t        sb[$];
    int          last_rd = 0;
    int          rd_cnt  = 0;
    int          wr_cnt  = 0;

    always @(negedge clk) begin
      exp_t e;
      if (bus.rd) begin
        last_rd = cyc;
        rd_cnt++;
        bus.entry_1 = (qa.size() > 0) ? qa.pop_front() : 16'h0000;
        bus.entry_2 = (qb.size() > 0) ? qb.pop_front() : 16'h0000;
      end
      bus.empty_1 = (qa.size() == 0);
      bus.empty_2 = (qb.size() == 0);
      if (bus.wr) begin
        wr_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dut%0d unexpected_wr: got output_1=%h ovf=%0b, required no write", g, bus.output_1, bus.ovf);
        end else begin
          e = sb.pop_front();
          if (bus.output_1 !== e.res || bus.ovf !== e.ovf) begin
            errors++;
            $display("FAIL dut%0d result: got %h ovf=%0b, required %h ovf=%0b", g, bus.output_1, bus.ovf, e.res, e.ovf);
          end
          if (e.lat != 0) begin
            checks++;
            if (cyc - last_rd != e.lat) begin
              errors++;
              $display("FAIL dut%0d latency: got %0d, required %0d", g, cyc - last_rd, e.lat);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r, input logic o, input int lat);
    exp_t e;
    e = '{res: r, ovf: o, lat: lat};
    case (d)
      0: begin g_dut[0].sb.push_back(e); g_dut[0].qa.push_back(a); g_dut[0].qb.push_back(b); end
      1: begin g_dut[1].sb.push_back(e); g_dut[1].qa.push_back(a); g_dut[1].qb.push_back(b); end
      default: begin g_dut[2].sb.push_back(e); g_dut[2].qa.push_back(a); g_dut[2].qb.push_back(b); end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (g_dut[0].bus.rd) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (g_dut[0].sb.size() == 0 && g_dut[1].sb.size() == 0 && g_dut[2].sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (2) tick();
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int wr_before;
    g_dut[0].bus.full = 1'b0;
    g_dut[1].bus.full = 1'b0;
    g_dut[2].bus.full = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_out", {16'd0, g_dut[0].bus.output_1}, 32'h0);
    chk("reset_ovf", {31'd0, g_dut[0].bus.ovf}, 32'h0);
    chk("reset_rd",  {31'd0, g_dut[0].bus.rd}, 32'h0);
    chk("reset_wr",  {31'd0, g_dut[0].bus.wr}, 32'h0);
    reset = 1'b0;
    tick();

    // round + saturate
    push(0, 16'h0680, 16'h04C0, 16'h1EE0, 1'b0, 4);
    push(0, 16'hFE80, 16'h0200, 16'hFD00, 1'b0, 4);
    push(0, 16'h6400, 16'h0200, 16'h7FFF, 1'b1, 4);
    push(0, 16'h9C00, 16'h0200, 16'h8000, 1'b1, 4);
    push(0, 16'h0001, 16'h0080, 16'h0001, 1'b0, 4);
    push(0, 16'h0001, 16'h00C0, 16'h0001, 1'b0, 4);
    push(0, 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 4);
    push(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 4);
    // round + wrap
    push(1, 16'h6400, 16'h0200, 16'hC800, 1'b1, 4);
    push(1, 16'h0680, 16'h04C0, 16'h1EE0, 1'b0, 4);
    push(1, 16'h9C00, 16'h0200, 16'h3800, 1'b1, 4);
    push(1, 16'h7FFF, 16'h7FFF, 16'hFF00, 1'b1, 4);
    // truncate + saturate
    push(2, 16'h0001, 16'h0080, 16'h0000, 1'b0, 4);
    push(2, 16'h0001, 16'h00C0, 16'h0000, 1'b0, 4);
    push(2, 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 4);
    push(2, 16'h0680, 16'h04C0, 16'h1EE0, 1'b0, 4);
    push(2, 16'h9C00, 16'h0200, 16'h8000, 1'b1, 4);
    drain("drain_vectors");

    // one empty input blocks the node
    g_dut[0].qa.push_back(16'h0100);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rd_blocked", {31'd0, g_dut[0].bus.rd}, 32'h0);
    end
    g_dut[0].sb.push_back('{res: 16'h0100, ovf: 1'b0, lat: 4});
    g_dut[0].qb.push_back(16'h0100);
    drain("drain_empty");

    // back-pressure: full held through RND and HOLD
    g_dut[0].bus.full = 1'b1;
    push(0, 16'h0680, 16'h04C0, 16'h1EE0, 1'b0, 11);
    wait_rd0(ok);
    chk("full_rd_seen", {31'd0, ok}, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 3) chk("full_wr_low", {31'd0, g_dut[0].bus.wr}, 32'h0);
      if (k >= 4) chk("full_out_stable", {16'd0, g_dut[0].bus.output_1}, 32'h1EE0);
      if (k == 10) g_dut[0].bus.full = 1'b0;
    end
    drain("drain_full");

    // reset while in HOLD discards the token
    g_dut[0].bus.full = 1'b1;
    g_dut[0].qa.push_back(16'h0200);
    g_dut[0].qb.push_back(16'h0300);
    wait_rd0(ok);
    chk("hold_rd_seen", {31'd0, ok}, 32'h1);
    repeat (5) tick();
    chk("hold_out", {16'd0, g_dut[0].bus.output_1}, 32'h0600);
    wr_before = g_dut[0].wr_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_hold_out", {16'd0, g_dut[0].bus.output_1}, 32'h0);
    chk("rst_hold_ovf", {31'd0, g_dut[0].bus.ovf}, 32'h0);
    chk("rst_hold_wr",  {31'd0, g_dut[0].bus.wr}, 32'h0);
    g_dut[0].bus.full = 1'b0;
    repeat (10) tick();
    chk("rst_hold_no_wr", g_dut[0].wr_cnt - wr_before, 32'd0);
    push(0, 16'h0200, 16'h0300, 16'h0600, 1'b0, 4);
    push(0, 16'h9C00, 16'h0200, 16'h8000, 1'b1, 4);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
